// File: rtl/add_subt_sched.sv
// ---------------------------------------------------------------------------
// add_subt_sched
//
// Scheduler and sequencer for the shared registered add/subtract datapath.
// Two requesters (0: FPU add path, 1: LN iteration unit) compete for the
// datapath. A round-robin arbiter grants one of them. The sequencer then drives
// operands, op and a single load strobe, and captures the registered sum and
// carry. The captured result, carry-derived flags and requester id are returned
// over a valid/ready response port. Only one operation is in flight at a time.
//
// Optional feature macro: ADD_SUBT_SCHED_PERF_EN
//   When defined, the CTR_W parameter and the util_cnt_o port exist. util_cnt_o
//   is a saturating count of busy cycles.
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   req_valid_i   [1:0]       per-requester request valid
//   req_ready_o   [1:0]       per-requester accept (one-hot or zero), combinational
//   req_op_i      [1:0]       per-requester op: 0 add, 1 subtract
//   req_a_i       [2*SWR-1:0] operand A, requester n at [n*SWR +: SWR]
//   req_b_i       [2*SWR-1:0] operand B, same packing
//   dp_load_o     datapath register load strobe (one cycle per operation)
//   dp_op_o       datapath Add_Sub_op
//   dp_a_o        [SWR-1:0]   datapath operand A
//   dp_b_o        [SWR-1:0]   datapath operand B (un-inverted)
//   dp_result_i   [SWR-1:0]   datapath registered sum
//   dp_c_i        datapath registered carry-out
//   rsp_valid_o   response valid
//   rsp_ready_i   response accept
//   rsp_id_o      requester the response belongs to
//   rsp_result_o  [SWR-1:0]   captured sum
//   rsp_ovf_o     add produced a carry-out (result needs 1-bit right normalise)
//   rsp_neg_o     subtract without carry-out (A<B, result is 2's complement)
//   busy_o        high in every state except IDLE
//   util_cnt_o    [CTR_W-1:0] busy-cycle counter (ADD_SUBT_SCHED_PERF_EN only)
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; grant and latch operands on accept
// ISSUE | dp_load_o pulses; datapath registers the operation
// CAPT  | datapath outputs valid; result and flags captured
// RESP  | rsp_valid_o high, held until rsp_ready_i
// ---------------------------------------------------------------------------
module add_subt_sched #(
  parameter int SWR = 26
`ifdef ADD_SUBT_SCHED_PERF_EN
  ,
  parameter int CTR_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [2*SWR-1:0] req_a_i,
  input  logic [2*SWR-1:0] req_b_i,
  output logic             dp_load_o,
  output logic             dp_op_o,
  output logic [SWR-1:0]   dp_a_o,
  output logic [SWR-1:0]   dp_b_o,
  input  logic [SWR-1:0]   dp_result_i,
  input  logic             dp_c_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [SWR-1:0]   rsp_result_o,
  output logic             rsp_ovf_o,
  output logic             rsp_neg_o,
  output logic             busy_o
`ifdef ADD_SUBT_SCHED_PERF_EN
  ,
  output logic [CTR_W-1:0] util_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;

  // Pointer holds the id of the last grant; it resets to 1 so that
  // requester 0 wins the first contested arbitration.
  logic           rr_ptr_q;
  logic           id_q;

  logic           grant_any;
  logic           grant_id;
  logic           accept;

  logic           sel_op;
  logic [SWR-1:0] sel_a;
  logic [SWR-1:0] sel_b;

  // -------------------------------------------------------------------------
  // Round-robin arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    grant_any = |req_valid_i;
    if (&req_valid_i) begin
      grant_id = ~rr_ptr_q;
    end else begin
      grant_id = req_valid_i[1];
    end
  end

  // Operand select for the granted requester
  always_comb begin
    if (grant_id) begin
      sel_op = req_op_i[1];
      sel_a  = req_a_i[2*SWR-1:SWR];
      sel_b  = req_b_i[2*SWR-1:SWR];
    end else begin
      sel_op = req_op_i[0];
      sel_a  = req_a_i[SWR-1:0];
      sel_b  = req_b_i[SWR-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and strobes
  // req_ready_o is combinational. It is qualified with rst so that no accept
  // is signalled while reset is held, even with a request pending.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    req_ready_o = 2'b00;
    dp_load_o   = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_any && rst) begin
          accept      = 1'b1;
          req_ready_o = grant_id ? 2'b10 : 2'b01;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dp_load_o = 1'b1;
        state_d   = S_CAPT;
      end
      S_CAPT: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o   = (state_q != S_IDLE);
  assign rsp_id_o = id_q;

  // -------------------------------------------------------------------------
  // Grant bookkeeping and datapath operand registers.
  // Operands stay put after ISSUE; the datapath ignores them while load is
  // low, and holding them avoids needless toggling on the wide buses.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 1'b1;
      id_q     <= 1'b0;
      dp_op_o  <= 1'b0;
      dp_a_o   <= '0;
      dp_b_o   <= '0;
    end else if (accept) begin
      rr_ptr_q <= grant_id;
      id_q     <= grant_id;
      dp_op_o  <= sel_op;
      dp_a_o   <= sel_a;
      dp_b_o   <= sel_b;
    end
  end

  // -------------------------------------------------------------------------
  // Response capture.
  // The datapath computes A + ~B + 1 for subtract, so carry-out there means
  // A >= B. Flags come from carry and op only, never from the sum bits.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_result_o <= '0;
      rsp_ovf_o    <= 1'b0;
      rsp_neg_o    <= 1'b0;
    end else if (state_q == S_CAPT) begin
      rsp_result_o <= dp_result_i;
      rsp_ovf_o    <= ~dp_op_o & dp_c_i;
      rsp_neg_o    <= dp_op_o & ~dp_c_i;
    end
  end

  // -------------------------------------------------------------------------
  // Utilisation counter
  // -------------------------------------------------------------------------
`ifdef ADD_SUBT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      util_cnt_o <= '0;
    end else if (busy_o && (util_cnt_o != {CTR_W{1'b1}})) begin
      util_cnt_o <= util_cnt_o + {{(CTR_W-1){1'b0}}, 1'b1};
    end
  end
`else
  // No utilisation counter in this build.
`endif

endmodule

// File: tb/tb_add_subt_sched.sv
`timescale 1ns/1ps
module tb_add_subt_sched;
  localparam int SWR = 26;
  localparam logic [SWR-1:0] MAXV = {SWR{1'b1}};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_op = 2'b00;
  logic [2*SWR-1:0] req_a = '0;
  logic [2*SWR-1:0] req_b = '0;
  logic             rsp_ready = 1'b0;
  logic [SWR-1:0]   dp_result;
  logic             dp_c;

  logic [1:0]       req_ready;
  logic             dp_load, dp_op;
  logic [SWR-1:0]   dp_a, dp_b;
  logic             rsp_valid, rsp_id, rsp_ovf, rsp_neg, busy;
  logic [SWR-1:0]   rsp_result;
`ifdef ADD_SUBT_SCHED_PERF_EN
  logic [15:0]      util_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt[2];
  int seen[2];

  add_subt_sched #(.SWR(SWR)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b),
    .dp_load_o(dp_load), .dp_op_o(dp_op), .dp_a_o(dp_a), .dp_b_o(dp_b),
    .dp_result_i(dp_result), .dp_c_i(dp_c),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_ovf_o(rsp_ovf), .rsp_neg_o(rsp_neg),
    .busy_o(busy)
`ifdef ADD_SUBT_SCHED_PERF_EN
    , .util_cnt_o(util_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  // Stand-in for the registered add/subtract datapath
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_result <= '0;
      dp_c      <= 1'b0;
    end else if (dp_load) begin
      {dp_c, dp_result} <= {1'b0, dp_a} + {1'b0, (dp_op ? ~dp_b : dp_b)} + {{SWR{1'b0}}, dp_op};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {carry, sum} from plain integer maths
  function automatic logic [SWR:0] ref_calc(input logic op, input logic [SWR-1:0] a,
                                            input logic [SWR-1:0] b);
    longint la, lb, r;
    logic   cy;
    la = longint'(a);
    lb = longint'(b);
    if (!op) begin
      r  = la + lb;
      cy = (r >= (longint'(1) << SWR));
    end else begin
      r  = la - lb;
      cy = (la >= lb);
    end
    r = r & ((longint'(1) << SWR) - 1);
    return {cy, r[SWR-1:0]};
  endfunction

  // ---------------- behavioural model + compare process ----------------
  logic           m_busy;
  int             m_age;
  logic           m_ptr, m_id, m_op, m_ovf, m_neg, m_g;
  logic [SWR-1:0] m_a, m_b, m_res;
  logic [SWR:0]   m_r;
  logic [1:0]     m_exp_rdy;
  int unsigned    m_util;

  initial begin
    m_busy = 0; m_age = 0; m_ptr = 1; m_id = 0; m_op = 0;
    m_a = '0; m_b = '0; m_res = '0; m_ovf = 0; m_neg = 0; m_util = 0;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_load", dp_load, 0);
        chk("rst_dp_op", dp_op, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_b", dp_b, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_rsp_neg", rsp_neg, 0);
        chk("rst_busy", busy, 0);
`ifdef ADD_SUBT_SCHED_PERF_EN
        chk("rst_util", util_cnt, 0);
`endif
        m_busy = 0; m_age = 0; m_ptr = 1; m_id = 0; m_op = 0;
        m_a = '0; m_b = '0; m_util = 0;
      end else begin
        chk("dp_a", dp_a, m_a);
        chk("dp_b", dp_b, m_b);
        chk("dp_op", dp_op, m_op);
`ifdef ADD_SUBT_SCHED_PERF_EN
        chk("util", util_cnt, m_util);
        if (m_busy && m_util != 32'd65535) m_util++;
`endif
        if (!m_busy) begin
          if (req_valid == 2'b11) m_g = ~m_ptr;
          else m_g = req_valid[1];
          m_exp_rdy = (req_valid == 2'b00) ? 2'b00 : (m_g ? 2'b10 : 2'b01);
          chk("idle_ready", req_ready, m_exp_rdy);
          chk("idle_busy", busy, 0);
          chk("idle_load", dp_load, 0);
          chk("idle_rsp_valid", rsp_valid, 0);
          if (req_valid != 2'b00) begin
            m_busy = 1; m_age = 1; m_ptr = m_g; m_id = m_g;
            m_op = req_op[m_g];
            m_a  = m_g ? req_a[2*SWR-1:SWR] : req_a[SWR-1:0];
            m_b  = m_g ? req_b[2*SWR-1:SWR] : req_b[SWR-1:0];
            m_r  = ref_calc(m_op, m_a, m_b);
            m_res = m_r[SWR-1:0];
            m_ovf = !m_op && m_r[SWR];
            m_neg = m_op && !m_r[SWR];
            acc_cnt[m_g] = acc_cnt[m_g] + 1;
          end
        end else begin
          chk("busy_ready", req_ready, 0);
          chk("busy_busy", busy, 1);
          chk("busy_load", dp_load, (m_age == 1));
          chk("busy_rsp_valid", rsp_valid, (m_age == 3));
          if (m_age == 3) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_ovf", rsp_ovf, m_ovf);
            chk("rsp_neg", rsp_neg, m_neg);
            if (rsp_ready) m_busy = 0;
          end else begin
            m_age++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SWR-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return MAXV;
      2: return 1;
      default: return SWR'($urandom);
    endcase
  endfunction

  task automatic set_req(input int n, input logic op, input logic [SWR-1:0] a,
                         input logic [SWR-1:0] b);
    req_op[n] = op;
    req_a[n*SWR +: SWR] = a;
    req_b[n*SWR +: SWR] = b;
  endtask

  // Single directed operation from an idle scheduler; called at posedge+1.
  task automatic do_op(input int n, input logic op, input logic [SWR-1:0] a,
                       input logic [SWR-1:0] b, input logic [SWR-1:0] l_res,
                       input logic l_ovf, input logic l_neg);
    set_req(n, op, a, b);
    req_valid = (n == 1) ? 2'b10 : 2'b01;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("d_ready_same_cycle", req_ready, (n == 1) ? 2'b10 : 2'b01);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    chk("d_load_T1", dp_load, 1);
    cyc();
    @(negedge clk);
    chk("d_load_T2", dp_load, 0);
    chk("d_valid_T2", rsp_valid, 0);
    cyc();
    @(negedge clk);
    chk("d_valid_T3", rsp_valid, 1);
    chk("d_result", rsp_result, l_res);
    chk("d_id", rsp_id, n);
    chk("d_ovf", rsp_ovf, l_ovf);
    chk("d_neg", rsp_neg, l_neg);
    cyc();
  endtask

  int gseq[8];
  int ng, nload;
  logic [SWR:0] pin;

  initial begin
    #1 rst = 1'b0;
    // Hand-computed pins on the reference arithmetic
    pin = ref_calc(1'b0, 'h10, 'h5);       chk("pin_add", pin, {1'b0, 26'h0000015});
    pin = ref_calc(1'b0, MAXV, 'h1);       chk("pin_add_wrap", pin, {1'b1, 26'h0000000});
    pin = ref_calc(1'b1, 'h7, 'h5);        chk("pin_sub_pos", pin, {1'b1, 26'h0000002});
    pin = ref_calc(1'b1, 'h5, 'h7);        chk("pin_sub_neg", pin, {1'b0, 26'h3FFFFFE});
    repeat (3) cyc();
    rst = 1'b1;

    do_op(0, 1'b0, 'h10, 'h5, 'h15, 1'b0, 1'b0);
    do_op(1, 1'b0, MAXV, 'h1, 'h0, 1'b1, 1'b0);
    do_op(0, 1'b1, 'h7, 'h5, 'h2, 1'b0, 1'b0);
    do_op(1, 1'b1, 'h5, 'h7, 'h3FFFFFE, 1'b0, 1'b1);

    // Both requesters held valid: alternate grants starting with 0
    rst = 1'b0; cyc(); cyc(); rst = 1'b1;
    set_req(0, 1'b0, 'h1, 'h2);
    set_req(1, 1'b1, 'h9, 'h4);
    req_valid = 2'b11; rsp_ready = 1'b1;
    ng = 0; nload = 0;
    repeat (16) begin
      @(negedge clk);
      if (req_ready != 2'b00 && ng < 8) begin gseq[ng] = int'(req_ready[1]); ng++; end
      if (dp_load) nload++;
      cyc();
    end
    req_valid = 2'b00;
    chk("rr_grants", ng, 4);
    chk("rr_g0", gseq[0], 0);
    chk("rr_g1", gseq[1], 1);
    chk("rr_g2", gseq[2], 0);
    chk("rr_g3", gseq[3], 1);
    chk("rr_loads", nload, 4);

    // Backpressure in RESP for 10 cycles with requester 1 waiting
    set_req(0, 1'b0, 'h123, 'h23);
    set_req(1, 1'b0, 'h1, 'h1);
    req_valid = 2'b01; rsp_ready = 1'b0;
    cyc(); req_valid = 2'b10;
    cyc(); cyc();
    repeat (10) begin
      @(negedge clk);
      chk("bp_ready", req_ready, 0);
      chk("bp_load", dp_load, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 'h146);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("bp_next_grant", req_ready, 2'b10);
    cyc(); req_valid = 2'b00;
    cyc(); cyc(); cyc();

    // Reset during CAPT, then a requester-1-only request
    set_req(0, 1'b0, 'h55, 'h11);
    req_valid = 2'b01;
    cyc(); req_valid = 2'b00;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_now_busy", busy, 0);
    chk("rst_now_dp_a", dp_a, 0);
    chk("rst_now_valid", rsp_valid, 0);
    @(negedge clk);
    cyc();
    rst = 1'b1;
    set_req(1, 1'b1, 'h20, 'h8);
    req_valid = 2'b10;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 2'b10);
    cyc(); req_valid = 2'b00;
    cyc(); cyc();
    @(negedge clk);
    chk("post_rst_valid", rsp_valid, 1);
    chk("post_rst_result", rsp_result, 'h18);
    chk("post_rst_id", rsp_id, 1);
    cyc();

    // Randomised traffic against the model
    seen[0] = acc_cnt[0];
    seen[1] = acc_cnt[1];
    repeat (4000) begin
      for (int n = 0; n < 2; n++) begin
        if (acc_cnt[n] != seen[n]) begin
          seen[n] = acc_cnt[n];
          req_valid[n] = ($urandom_range(0, 1) == 1);
          set_req(n, 1'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
        end else if (req_valid[n] && $urandom_range(0, 15) == 0) begin
          req_valid[n] = 1'b0;
        end else if (!req_valid[n] && $urandom_range(0, 2) == 0) begin
          req_valid[n] = 1'b1;
          set_req(n, 1'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
      cyc();
    end
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (8) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
